alu_8b: RTL and testbench

//  Registered single-cycle integer ALU for the CSCI2500 datapath.

---
 rtl/alu_8b.sv | 133 +++++++++++++
 tb/tb_alu_8b.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alu_8b.sv
// rtl/alu_8b.sv - registered single-cycle integer ALU
//
// Purpose:
//   Combines operands a and b according to the 4-bit aluMode opcode and
//   registers the result on s, one clock after the operands are sampled.
//   Arithmetic wraps modulo 2^WIDTH; carry-out is not part of s.
//   Optional feature macro: ALU_FLAGS_EN adds a registered {N,Z,C,V} flags port.
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst_n    in   1      synchronous active-low reset (clears s and flags)
//   s        out  WIDTH  registered result
//   a        in   WIDTH  operand A
//   b        in   WIDTH  operand B
//   aluMode  in   4      operation select
//   flags    out  4      {N,Z,C,V}, registered with s (ALU_FLAGS_EN only)

module alu_8b #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] s,
`ifdef ALU_FLAGS_EN
  output logic [3:0]       flags,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluMode
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOR   = 4'h5;
  localparam logic [3:0] OP_NOT   = 4'h6;
  localparam logic [3:0] OP_SLL   = 4'h7;
  localparam logic [3:0] OP_SRL   = 4'h8;
  localparam logic [3:0] OP_SRA   = 4'h9;
  localparam logic [3:0] OP_ROL   = 4'hA;
  localparam logic [3:0] OP_ROR   = 4'hB;
  localparam logic [3:0] OP_SLT   = 4'hC;
  localparam logic [3:0] OP_SLTU  = 4'hD;
  localparam logic [3:0] OP_PASSA = 4'hE;
  localparam logic [3:0] OP_PASSB = 4'hF;

  // Shift/rotate amount: only the low log2(WIDTH) bits of b matter.
  logic [SHW-1:0]     w_sh;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_rol_wide;
  logic [2*WIDTH-1:0] w_ror_wide;
  logic [WIDTH-1:0]   w_result;
  logic               w_c;
  logic               w_v;

  assign w_sh   = b[SHW-1:0];
  // One extra bit captures carry-out (ADD) and borrow (SUB).
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
  // Rotation as a shift of a doubled operand: the wrapped bits fall into
  // the half that is kept.
  assign w_rol_wide = {a, a} << w_sh;
  assign w_ror_wide = {a, a} >> w_sh;

  always_comb begin
    w_result = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    case (aluMode)
      OP_ADD: begin
        w_result = w_sum[WIDTH-1:0];
        w_c      = w_sum[WIDTH];
        w_v      = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_result = w_diff[WIDTH-1:0];
        w_c      = w_diff[WIDTH];
        w_v      = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   w_result = a & b;
      OP_OR:    w_result = a | b;
      OP_XOR:   w_result = a ^ b;
      OP_NOR:   w_result = ~(a | b);
      OP_NOT:   w_result = ~a;
      OP_SLL:   w_result = a << w_sh;
      OP_SRL:   w_result = a >> w_sh;
      OP_SRA:   w_result = $unsigned($signed(a) >>> w_sh);
      OP_ROL:   w_result = w_rol_wide[2*WIDTH-1:WIDTH];
      OP_ROR:   w_result = w_ror_wide[WIDTH-1:0];
      OP_SLT:   w_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  w_result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_PASSA: w_result = a;
      OP_PASSB: w_result = b;
      default:  w_result = '0;
    endcase
  end

  logic [WIDTH-1:0] r_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s <= '0;
    end else begin
      r_s <= w_result;
    end
  end

  assign s = r_s;

`ifdef ALU_FLAGS_EN
  logic [3:0] r_flags;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags <= 4'h0;
    end else begin
      r_flags <= {w_result[WIDTH-1], (w_result == '0), w_c, w_v};
    end
  end

  assign flags = r_flags;
`else
  // Carry/overflow only feed the flags register; keep them referenced.
  logic w_unused;
  assign w_unused = w_c ^ w_v;
`endif

endmodule

// File: tb/tb_alu_8b.sv
// tb/tb_alu_8b.sv - directed self-checking bench for alu_8b

module tb_alu_8b;

  logic       clk;
  logic       rst_n;
  logic [7:0] s;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] aluMode;
`ifdef ALU_FLAGS_EN
  logic [3:0] flags;
`endif

  int n_cmp;
  int n_bad;

  alu_8b #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s       (s),
`ifdef ALU_FLAGS_EN
    .flags   (flags),
`endif
    .a       (a),
    .b       (b),
    .aluMode (aluMode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Drive operands away from the edge, clock once, sample 1 time unit later.
  task automatic apply(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] im);
    @(negedge clk);
    a       = ia;
    b       = ib;
    aluMode = im;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [3:0] vm;
    logic [7:0] vs;
  } vec_t;

  vec_t vecs[$];

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    a       = 8'hFF;
    b       = 8'hFF;
    aluMode = 4'h0;

    // Reset held two cycles with an ADD pending on the inputs.
    @(posedge clk);
    #1;
    check_val("reset_c1", s, 8'h00);
    @(posedge clk);
    #1;
    check_val("reset_c2", s, 8'h00);
`ifdef ALU_FLAGS_EN
    check_val("reset_flags", {4'h0, flags}, 8'h00);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_reset_add", s, 8'hFE);

    vecs = '{
      '{8'hAB, 8'hCB, 4'h0, 8'h76},
      '{8'hAB, 8'hCB, 4'h1, 8'hE0},
      '{8'hAB, 8'hCB, 4'h2, 8'h8B},
      '{8'hAB, 8'hCB, 4'h3, 8'hEB},
      '{8'hAB, 8'hCB, 4'h4, 8'h60},
      '{8'hAB, 8'hCB, 4'h5, 8'h14},
      '{8'hAB, 8'hCB, 4'h6, 8'h54},
      '{8'hAB, 8'hCB, 4'hE, 8'hAB},
      '{8'hAB, 8'hCB, 4'hF, 8'hCB},
      '{8'h6F, 8'hE1, 4'h0, 8'h50},
      '{8'h6F, 8'hE1, 4'h1, 8'h8E},
      '{8'h6F, 8'hE1, 4'h2, 8'h61},
      '{8'h6F, 8'hE1, 4'h3, 8'hEF},
      '{8'h96, 8'h03, 4'h7, 8'hB0},
      '{8'h96, 8'h03, 4'h8, 8'h12},
      '{8'h96, 8'h03, 4'h9, 8'hF2},
      '{8'h96, 8'h03, 4'hA, 8'hB4},
      '{8'h96, 8'h03, 4'hB, 8'hD2},
      '{8'h96, 8'hFB, 4'h7, 8'hB0},   // upper b bits ignored (amount 3)
      '{8'h96, 8'hF8, 4'h8, 8'h96},   // amount 0 returns a
      '{8'h96, 8'h08, 4'hA, 8'h96},
      '{8'h80, 8'h01, 4'hC, 8'h01},
      '{8'h80, 8'h01, 4'hD, 8'h00},
      '{8'h5A, 8'h5A, 4'hC, 8'h00},
      '{8'h5A, 8'h5A, 4'hD, 8'h00},
      '{8'h5A, 8'h5A, 4'h1, 8'h00}
    };

    foreach (vecs[i]) begin
      apply(vecs[i].va, vecs[i].vb, vecs[i].vm);
      check_val($sformatf("op%0h_%02h_%02h", vecs[i].vm, vecs[i].va, vecs[i].vb), s, vecs[i].vs);
    end

`ifdef ALU_FLAGS_EN
    apply(8'h5A, 8'h5A, 4'h1);
    check_val("flags_sub_eq", {4'h0, flags}, 8'h04);      // N0 Z1 C0 V0
    apply(8'h7F, 8'h01, 4'h0);
    check_val("s_add_ovf", s, 8'h80);
    check_val("flags_add_ovf", {4'h0, flags}, 8'h09);     // N1 Z0 C0 V1
    apply(8'hAB, 8'hCB, 4'h0);
    check_val("flags_add_cv", {4'h0, flags}, 8'h03);      // N0 Z0 C1 V1
    apply(8'h01, 8'h02, 4'h1);
    check_val("flags_sub_borrow", {4'h0, flags}, 8'h0A);  // FF: N1 Z0 C1 V0
    apply(8'hFF, 8'h01, 4'h2);
    check_val("flags_logic", {4'h0, flags}, 8'h00);       // 01: C/V forced 0
`endif

    // Reset wins over an operation applied in the same cycle.
    apply(8'h12, 8'h34, 4'h0);
    check_val("pre_reset_add", s, 8'h46);
    @(negedge clk);
    rst_n = 1'b0;
    a     = 8'h0F;
    b     = 8'h01;
    @(posedge clk);
    #1;
    check_val("reset_override", s, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("resume_after_reset", s, 8'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
